// File: rtl/bcd_7seg_scan.sv
// rtl/bcd_7seg_scan.sv - multiplexed 7-segment scan driver with frame-aligned BCD commit
// Optional feature macro: BCD7_LZ_BLANK_EN (leading-zero blanking).
module bcd_7seg_scan #(
   parameter int NUM_DIGITS     = 5,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYC      = 4,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [4*NUM_DIGITS-1:0] dbcd_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int   CNT_W = $clog2(CLK_DIV);
   localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic POL   = (SEG_ACTIVE_LOW != 0);

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic                    wrap_tick;

   logic                    pending;
   logic                    ready_q;
   logic [4*NUM_DIGITS-1:0] pend_bcd;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic [4*NUM_DIGITS-1:0] disp_reg;
   logic [NUM_DIGITS-1:0]   dp_reg;

   logic [NUM_DIGITS-1:0]   lz;
   logic [3:0]              sel_nib;
   logic                    sel_dp;
   logic                    sel_blank;

   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    frame_q;

   // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
   assign wrap_tick = tick && (idx == IDX_W'(NUM_DIGITS - 1));

   // Slot prescaler and digit index; index advances once per slot and wraps per frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
         idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Accept one value into the pending buffer; move it to the display only at a frame wrap.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending  <= 1'b0;
         ready_q  <= 1'b1;
         pend_bcd <= '0;
         pend_dp  <= '0;
         disp_reg <= '0;
         dp_reg   <= '0;
      end else if (valid_i && ready_q) begin
         pend_bcd <= dbcd_i;
         pend_dp  <= dp_i;
         pending  <= 1'b1;
         ready_q  <= 1'b0;
      end else if (wrap_tick && pending) begin
         disp_reg <= pend_bcd;
         dp_reg   <= pend_dp;
         pending  <= 1'b0;
         ready_q  <= 1'b1;
      end
   end

`ifdef BCD7_LZ_BLANK_EN
   logic run_zero;

   // Digit k blanks when it and every digit above it are zero; digit 0 is always shown.
   always_comb begin
      lz       = '0;
      run_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         run_zero = run_zero & (disp_reg[4*k +: 4] == 4'd0);
         lz[k]    = run_zero;
      end
   end
`else
   assign lz = '0;
`endif

   // Pick the nibble, decimal point and blank flag of the digit currently being scanned.
   always_comb begin
      sel_nib   = 4'd0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            sel_nib   = disp_reg[4*k +: 4];
            sel_dp    = dp_reg[k];
            sel_blank = lz[k];
         end
      end
   end

   // Registered output stage: ghosting guard at slot start, then the selected digit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seg_q   <= '0;
         dp_q    <= 1'b0;
         an_q    <= '0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= wrap_tick;
         if (cnt < CNT_W'(BLANK_CYC)) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
         end else begin
            seg_q <= sel_blank ? 7'h00 : decode(sel_nib);
            dp_q  <= sel_dp;
            an_q  <= NUM_DIGITS'(1) << idx;
         end
      end
   end

   assign seg_o   = seg_q ^ {7{POL}};
   assign dp_o    = dp_q ^ POL;
   assign an_o    = an_q ^ {NUM_DIGITS{POL}};
   assign frame_o = frame_q;
   assign ready_o = ready_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// tb/tb_bcd_7seg_scan.sv - scoreboard bench for bcd_7seg_scan with a frame-level display model
module tb_bcd_7seg_scan;

   localparam int ND = 5;
   localparam int CD = 8;
   localparam int BC = 2;
   localparam int FR = ND * CD;

   localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic          clk = 1'b0;
   logic          rst;
   logic [19:0]   dbcd = '0;
   logic [4:0]    dp_in = '0;
   logic          valid = 1'b0;
   logic          ready;
   logic [6:0]    seg;
   logic          dp_out;
   logic [4:0]    an;
   logic          frame;

   bcd_7seg_scan #(
      .NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(BC), .SEG_ACTIVE_LOW(0)
   ) dut (
      .clk_i(clk), .rst_i(rst), .dbcd_i(dbcd), .dp_i(dp_in), .valid_i(valid),
      .ready_o(ready), .seg_o(seg), .dp_o(dp_out), .an_o(an), .frame_o(frame)
   );

   always #5 clk = ~clk;

   // st = clock edges since reset release = index of the scan state currently held
   int st;
   always @(posedge clk or posedge rst) begin
      if (rst) st <= 0;
      else     st <= st + 1;
   end

   typedef struct {
      logic [19:0] val;
      logic [4:0]  dp;
      int          from;
   } entry_t;

   entry_t sb[$];
   int     last_c    = -1;
   int     last_from = 0;
   int     nvec      = 0;
   int     nerr      = 0;

   function automatic logic [6:0] exp_seg(logic [19:0] v, int d);
      logic [19:0] above;
      int          n;
      above = v >> (4 * d);
      n     = int'(above & 20'hF);
`ifdef BCD7_LZ_BLANK_EN
      if (d > 0 && above == 20'h0) return 7'h00;
`endif
      if (n > 9) return 7'h40;
      return SEG_TBL[n];
   endfunction

   function automatic bit model_ready(int s);
      return !(last_c < s && s < last_from);
   endfunction

   task automatic check(string name, int act, int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s state=%0d got=%0h expected=%0h", name, st, act, exp);
      end
   endtask

   // Monitor: at each falling edge compare the outputs against the display model
   initial begin : monitor
      logic [19:0] cur;
      logic [4:0]  cur_dp;
      int          rd;
      int          s;
      int          cnt;
      int          dig;
      cur    = '0;
      cur_dp = '0;
      rd     = 0;
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            #1;
            check("rst_an", an, 0);
            check("rst_seg", seg, 0);
            check("rst_dp", dp_out, 0);
            check("rst_ready", ready, 1);
            check("rst_frame", frame, 0);
            cur    = '0;
            cur_dp = '0;
            rd     = sb.size();
         end else begin
            check("ready", ready, int'(model_ready(st)));
            if (st == 0) begin
               check("init_an", an, 0);
               check("init_seg", seg, 0);
               check("init_frame", frame, 0);
            end else begin
               s = st - 1;
               while (rd < sb.size() && sb[rd].from <= s) begin
                  cur    = sb[rd].val;
                  cur_dp = sb[rd].dp;
                  rd++;
               end
               cnt = s % CD;
               dig = (s / CD) % ND;
               check("frame", frame, int'((s % FR) == FR - 1));
               if (cnt < BC) begin
                  check("an_blank", an, 0);
                  check("seg_blank", seg, 0);
                  check("dp_blank", dp_out, 0);
               end else begin
                  check("an", an, 1 << dig);
                  check("seg", seg, exp_seg(cur, dig));
                  check("dp", dp_out, cur_dp[dig]);
               end
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Present a value for one cycle; record it only if the model says it is accepted
   task automatic offer(logic [19:0] v, logic [4:0] d);
      int s;
      int w;
      s     = st;
      dbcd  = v;
      dp_in = d;
      valid = 1'b1;
      if (model_ready(s)) begin
         w = (s / FR) * FR + FR - 1;
         if (w == s) w += FR;
         sb.push_back('{val: v, dp: d, from: w + 1});
         last_c    = s;
         last_from = w + 1;
      end
      tick(1);
      valid = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      last_c    = -1;
      last_from = 0;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin : stimulus
      logic [19:0] v;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(5);

      offer(20'h01234, 5'b00000);
      offer(20'h99999, 5'b11111);
      tick(90);

      for (int i = 0; i < 200; i++) begin
         if ((st % FR) == FR - 1 && model_ready(st)) break;
         tick(1);
      end
      offer(20'h56789, 5'b10001);
      tick(100);

      offer(20'h0000A, 5'b00100);
      tick(90);

      for (int i = 0; i < 40; i++) begin
         tick($urandom_range(0, 70));
         v = 20'($urandom);
         if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
         offer(v, 5'($urandom));
      end
      tick(90);

      offer(20'h43210, 5'b01010);
      for (int i = 0; i < 20; i++) begin
         if ((st % CD) == 4) break;
         tick(1);
      end
      do_reset();
      tick(100);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
